// File: rtl/lfsr_stream_checker.sv
// Receive-side checker for the 8-bit LFSR state stream: hunts for lock, flywheels once locked.
// Optional macro CHK_ZERO_TRAP_EN: an all-zero word sets zero_seen and forces LOCKED back to HUNT.
module lfsr_stream_checker #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned LOSS_CNT = 3,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_word_i,
    output logic             locked_o,
    output logic             sync_err_o,
    output logic [CNT_W-1:0] err_count_o,
    output logic [CNT_W-1:0] word_count_o,
    output logic             zero_seen_o
);

    localparam int unsigned RUN_W = 4;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] w);
        return {w[WIDTH-2:0], w[7] ^ w[5] ^ w[4] ^ w[3]};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    state_e             state_q, state_d;
    logic               have_prev_q, have_prev_d;
    logic [WIDTH-1:0]   prev_q, prev_d;
    logic [WIDTH-1:0]   exp_q, exp_d;
    logic [RUN_W-1:0]   match_run_q, match_run_d;
    logic [RUN_W-1:0]   miss_run_q, miss_run_d;
    logic               locked_q, locked_d;
    logic               sync_err_q, sync_err_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic               is_zero;
    logic               zero_trap;

    assign is_zero = (in_word_i == '0);

`ifdef CHK_ZERO_TRAP_EN
    logic zero_seen_q, zero_seen_d;
    assign zero_trap = in_valid_i & is_zero;
`else
    assign zero_trap = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_HUNT;
            have_prev_q <= 1'b0;
            prev_q      <= '0;
            exp_q       <= '0;
            match_run_q <= '0;
            miss_run_q  <= '0;
            locked_q    <= 1'b0;
            sync_err_q  <= 1'b0;
            err_cnt_q   <= '0;
            word_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            have_prev_q <= have_prev_d;
            prev_q      <= prev_d;
            exp_q       <= exp_d;
            match_run_q <= match_run_d;
            miss_run_q  <= miss_run_d;
            locked_q    <= locked_d;
            sync_err_q  <= sync_err_d;
            err_cnt_q   <= err_cnt_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    // Next-state: hunt for LOCK_CNT good transitions, then flywheel on own prediction
    always_comb begin
        state_d     = state_q;
        have_prev_d = have_prev_q;
        prev_d      = prev_q;
        exp_d       = exp_q;
        match_run_d = match_run_q;
        miss_run_d  = miss_run_q;
        sync_err_d  = 1'b0;
        err_cnt_d   = err_cnt_q;
        word_cnt_d  = word_cnt_q;

        if (in_valid_i) begin
            case (state_q)
                ST_HUNT: begin
                    if (have_prev_q && !is_zero && (in_word_i == lfsr_next(prev_q))) begin
                        match_run_d = match_run_q + RUN_W'(1);
                    end else begin
                        match_run_d = '0;
                    end
                    prev_d      = in_word_i;
                    have_prev_d = 1'b1;
                    if (match_run_d == RUN_W'(LOCK_CNT)) begin
                        state_d     = ST_LOCKED;
                        exp_d       = lfsr_next(in_word_i);
                        miss_run_d  = '0;
                        match_run_d = '0;
                    end
                end
                ST_LOCKED: begin
                    word_cnt_d = sat_inc(word_cnt_q);
                    exp_d      = lfsr_next(exp_q);
                    if (!is_zero && (in_word_i == exp_q)) begin
                        miss_run_d = '0;
                    end else begin
                        sync_err_d = 1'b1;
                        err_cnt_d  = sat_inc(err_cnt_q);
                        miss_run_d = miss_run_q + RUN_W'(1);
                        if ((miss_run_d == RUN_W'(LOSS_CNT)) || zero_trap) begin
                            state_d     = ST_HUNT;
                            have_prev_d = 1'b0;
                            match_run_d = '0;
                        end
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end

        // Clear beats a same-cycle increment; the lock state is untouched
        if (clr_i) begin
            err_cnt_d  = '0;
            word_cnt_d = '0;
        end

        locked_d = (state_d == ST_LOCKED);
    end

`ifdef CHK_ZERO_TRAP_EN
    always_comb begin
        zero_seen_d = zero_seen_q;
        if (zero_trap) zero_seen_d = 1'b1;
        if (clr_i)     zero_seen_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) zero_seen_q <= 1'b0;
        else     zero_seen_q <= zero_seen_d;
    end

    assign zero_seen_o = zero_seen_q;
`else
    assign zero_seen_o = 1'b0;
`endif

    assign locked_o     = locked_q;
    assign sync_err_o   = sync_err_q;
    assign err_count_o  = err_cnt_q;
    assign word_count_o = word_cnt_q;

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Directed self-checking bench for lfsr_stream_checker; follows CHK_ZERO_TRAP_EN like the RTL.
module tb_lfsr_stream_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_word = 8'h00;
    logic        locked;
    logic        sync_err;
    logic [15:0] err_count;
    logic [15:0] word_count;
    logic        zero_seen;

    int n_checks = 0;
    int n_fail   = 0;

    lfsr_stream_checker #(
        .WIDTH(8), .LOCK_CNT(4), .LOSS_CNT(3), .CNT_W(16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (clr),
        .in_valid_i   (in_valid),
        .in_word_i    (in_word),
        .locked_o     (locked),
        .sync_err_o   (sync_err),
        .err_count_o  (err_count),
        .word_count_o (word_count),
        .zero_seen_o  (zero_seen)
    );

    always #5 clk = ~clk;

    // Present one word for one cycle; returns on the next falling edge with outputs settled
    task automatic send(input logic [7:0] w);
        in_valid = 1'b1;
        in_word  = w;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({locked, sync_err, zero_seen} !== 3'b000 || err_count !== 16'd0 || word_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got lk=%b se=%b zs=%b err=%0d wc=%0d want all 0",
                     locked, sync_err, zero_seen, err_count, word_count);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_lock();
        logic [7:0] seq [5] = '{8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0};
        for (int i = 0; i < 5; i++) begin
            send(seq[i]);
            n_checks++;
            if (locked !== (i == 4)) begin
                n_fail++;
                $display("FAIL lock_step%0d locked got %b want %b", i, locked, (i == 4));
            end
        end
        n_checks++;
        if (err_count !== 16'd0 || word_count !== 16'd0) begin
            n_fail++;
            $display("FAIL lock_counts got err=%0d wc=%0d want 0/0", err_count, word_count);
        end
    endtask

    task automatic test_continue();
        send(8'hE1);
        n_checks++;
        if (sync_err !== 1'b0) begin
            n_fail++;
            $display("FAIL cont_e1_sync_err got %b want 0", sync_err);
        end
        send(8'hC2);
        n_checks++;
        if (word_count !== 16'd2 || sync_err !== 1'b0 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL cont_c2 got wc=%0d se=%b lk=%b want 2/0/1", word_count, sync_err, locked);
        end
    endtask

    // Expected word is 85; corrupt it, then resume with 0B
    task automatic test_single_corruption();
`ifdef CHK_ZERO_TRAP_EN
        send(8'h5A);
`else
        send(8'h00);
`endif
        n_checks++;
        if (sync_err !== 1'b1 || err_count !== 16'd1 || locked !== 1'b1 || zero_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL corrupt_word got se=%b err=%0d lk=%b zs=%b want 1/1/1/0",
                     sync_err, err_count, locked, zero_seen);
        end
        send(8'h0B);
        n_checks++;
        if (sync_err !== 1'b0 || err_count !== 16'd1 || locked !== 1'b1 || word_count !== 16'd4) begin
            n_fail++;
            $display("FAIL corrupt_recover got se=%b err=%0d lk=%b wc=%0d want 0/1/1/4",
                     sync_err, err_count, locked, word_count);
        end
    endtask

    task automatic test_loss();
        for (int i = 0; i < 3; i++) begin
            send(8'h55);
            n_checks++;
            if (sync_err !== 1'b1 || err_count !== 16'(2 + i) || locked !== (i != 2)) begin
                n_fail++;
                $display("FAIL loss_step%0d got se=%b err=%0d lk=%b want 1/%0d/%b",
                         i, sync_err, err_count, locked, 2 + i, (i != 2));
            end
        end
        n_checks++;
        if (word_count !== 16'd7) begin
            n_fail++;
            $display("FAIL loss_word_count got %0d want 7", word_count);
        end
    endtask

    task automatic test_resync();
        logic [7:0] seq [5] = '{8'h17, 8'h2F, 8'h5E, 8'hBC, 8'h78};
        for (int i = 0; i < 5; i++) begin
            send(seq[i]);
            n_checks++;
            if (locked !== (i == 4) || sync_err !== 1'b0) begin
                n_fail++;
                $display("FAIL resync_step%0d got lk=%b se=%b want %b/0", i, locked, sync_err, (i == 4));
            end
        end
        n_checks++;
        if (err_count !== 16'd4 || word_count !== 16'd7) begin
            n_fail++;
            $display("FAIL resync_counts got err=%0d wc=%0d want 4/7", err_count, word_count);
        end
    endtask

    task automatic test_gaps_clear();
        logic [7:0] seq [3] = '{8'hF1, 8'hE3, 8'hC6};
        for (int i = 0; i < 3; i++) begin
            send(seq[i]);
            repeat (10) begin
                @(negedge clk);
                n_checks++;
                if (sync_err !== 1'b0 || locked !== 1'b1) begin
                    n_fail++;
                    $display("FAIL gap_idle%0d got se=%b lk=%b want 0/1", i, sync_err, locked);
                end
            end
        end
        n_checks++;
        if (err_count !== 16'd4 || word_count !== 16'd10) begin
            n_fail++;
            $display("FAIL gap_counts got err=%0d wc=%0d want 4/10", err_count, word_count);
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        n_checks++;
        if (err_count !== 16'd0 || word_count !== 16'd0 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL clear got err=%0d wc=%0d lk=%b want 0/0/1", err_count, word_count, locked);
        end
    endtask

    // Expected word is 8D; the flywheel then predicts 1A
    task automatic test_clr_with_mismatch();
        clr = 1'b1;
        send(8'h33);
        clr = 1'b0;
        n_checks++;
        if (sync_err !== 1'b1 || err_count !== 16'd0 || word_count !== 16'd0 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_mismatch got se=%b err=%0d wc=%0d lk=%b want 1/0/0/1",
                     sync_err, err_count, word_count, locked);
        end
        send(8'h1A);
        n_checks++;
        if (sync_err !== 1'b0 || err_count !== 16'd0 || word_count !== 16'd1) begin
            n_fail++;
            $display("FAIL clr_followup got se=%b err=%0d wc=%0d want 0/0/1", sync_err, err_count, word_count);
        end
    endtask

`ifdef CHK_ZERO_TRAP_EN
    task automatic test_zero_trap();
        send(8'h00);
        n_checks++;
        if (zero_seen !== 1'b1 || sync_err !== 1'b1 || locked !== 1'b0 || err_count !== 16'd1) begin
            n_fail++;
            $display("FAIL zero_trap got zs=%b se=%b lk=%b err=%0d want 1/1/0/1",
                     zero_seen, sync_err, locked, err_count);
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        n_checks++;
        if (zero_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_clear got zs=%b want 0", zero_seen);
        end
        send(8'h00);
    endtask
`endif

    task automatic test_rst_midstream();
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({locked, sync_err, zero_seen} !== 3'b000 || err_count !== 16'd0 || word_count !== 16'd0) begin
            n_fail++;
            $display("FAIL rst_async got lk=%b se=%b zs=%b err=%0d wc=%0d want all 0",
                     locked, sync_err, zero_seen, err_count, word_count);
        end
        @(negedge clk);
        rst = 1'b0;
        begin
            logic [7:0] seq [5] = '{8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0};
            for (int i = 0; i < 5; i++) begin
                send(seq[i]);
                n_checks++;
                if (locked !== (i == 4)) begin
                    n_fail++;
                    $display("FAIL relock_step%0d locked got %b want %b", i, locked, (i == 4));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_continue();
        test_single_corruption();
        test_loss();
        test_resync();
        test_gaps_clear();
        test_clr_with_mismatch();
`ifdef CHK_ZERO_TRAP_EN
        test_zero_trap();
`endif
        test_rst_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr_stream_checker.md
Name: lfsr_stream_checker

Overview:
- Receive-side counterpart of the team's 8-bit LFSR random source.
- Consumes the raw LFSR state word stream, one word per generator enable, and self-synchronises to it.
- Verifies that every word is the correct successor of the previous one, and reports lock status, sync errors and error/word counts.
- Used on the verification/debug path to prove the random source, and any link carrying its stream, is intact.

Parameters:
- WIDTH, 8: word width; taps are fixed for 8 bits (feedback = w[7]^w[5]^w[4]^w[3], next = {w[6:0], feedback}).
- LOCK_CNT, 4: consecutive correct transitions required to enter LOCKED; legal range 1..15.
- LOSS_CNT, 3: consecutive mismatches in LOCKED required to fall back to HUNT; legal range 1..15.
- CNT_W, 16: width of err_count and word_count.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous clear of err_count, word_count and sticky flags; does not affect FSM or lock state.
- in_valid  input  1  in_word is valid this cycle (mirrors generator enable).
- in_word  input  WIDTH  LFSR state word under test.
- locked  output  1  checker is in LOCKED state.
- sync_err  output  1  one-cycle pulse on a mismatch while LOCKED.
- err_count  output  CNT_W  saturating count of LOCKED mismatches.
- word_count  output  CNT_W  saturating count of valid words accepted while LOCKED.
- zero_seen  output  1  sticky: an all-zero word was received (CHK_ZERO_TRAP_EN only; else tied 0).

Behaviour:
- Reset (rst=1, async):
  - FSM=HUNT, have_prev=0, match_run=0, miss_run=0, expected=0.
  - locked=0, sync_err=0, err_count=0, word_count=0, zero_seen=0.
- All outputs are registered; response appears one cycle after the in_valid cycle.
- in_valid=0: no state change; sync_err=0.
- HUNT, on in_valid:
  - If have_prev and in_word == next(prev_word): match_run++. Otherwise match_run=0.
  - prev_word<=in_word; have_prev<=1.
  - When match_run reaches LOCK_CNT: go to LOCKED, expected<=next(in_word), miss_run=0.
- LOCKED, on in_valid (flywheel):
  - Compare in_word with expected.
  - Match: miss_run=0, word_count++ (saturating), expected<=next(expected).
  - Mismatch: sync_err=1 for one cycle, err_count++ (saturating at all-ones), miss_run++, word_count++ (saturating), expected<=next(expected).
  - The flywheel advances from its own prediction, not from the input, so one corrupted word costs exactly one error.
  - When miss_run reaches LOSS_CNT: go to HUNT, locked=0, have_prev=0, match_run=0.
- clr together with a mismatch in the same cycle: clr wins; the counter reads 0; sync_err still pulses.
- Counters saturate and never wrap.
- rst mid-stream: immediate return to reset state; relock needs LOCK_CNT+1 fresh words.
- The all-zero word is never a legal successor; it always counts as a mismatch or non-match.

Optional Feature:
- CHK_ZERO_TRAP_EN defined:
  - A valid all-zero in_word in any state sets zero_seen (sticky until clr or rst).
  - From LOCKED it forces an immediate transition to HUNT, regardless of miss_run, with a sync_err pulse and err_count++.
- Not defined: all-zero is handled as an ordinary mismatch; zero_seen is constant 0.

Test Plan:
- Lock: after rst, feed valid FF,FE,FC,F8,F0 -> locked=1 one cycle after F0; err_count=0.
- Continue with E1,C2 -> word_count=2, sync_err stays 0.
- Single corruption: while locked and expecting E1, send 00 (macro off) then C2 -> exactly one sync_err pulse; err_count=1; locked stays 1.
- Loss: while locked, send 3 consecutive wrong words (55,55,55) -> err_count+=3; locked=0 one cycle after the third.
- Re-sync from HUNT then requires LOCK_CNT good transitions.
- Gaps and clear: locked stream with in_valid low for 10 cycles between words -> no errors.
  - Pulse clr -> err_count=0, word_count=0; locked unchanged.
- Zero trap (macro on): locked, send 00 -> zero_seen=1, sync_err pulse, locked=0 next cycle.
  - rst asserted mid-stream -> all outputs 0 asynchronously.
